run_ctrl_dump: RTL and testbench

- Synthesizable run-control and state-dump unit placed beside the single-cycle CPU.
- Gates CPU execution through a clock-enable and stops it on any of NUM_BP PC breakpoints, a cycle-count watchdog, or an external halt request.
- After stopping, it walks the register file through the CPU's reg_sel/reg_data debug port.
- It streams the halted PC plus all registers out over a valid/ready interface, then waits to be re-armed.

---
 rtl/run_ctrl_dump.sv | 133 +++++++++++++
 tb/tb_run_ctrl_dump.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/run_ctrl_dump.sv
// Run-control and state-dump unit for the single-cycle CPU: gates the CPU clock-enable,
// stops on breakpoint / watchdog / external halt, then streams PC + register file out.
module run_ctrl_dump #(
    parameter int NUM_BP = 2,
    parameter int PC_W   = 32,
    parameter int DATA_W = 32,
    parameter int NREG   = 32,
    parameter int SEL_W  = 5,
    parameter int CNT_W  = 16,
    localparam int BP_IDX_W = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     arm,
    input  logic                     halt_req,
    input  logic [NUM_BP-1:0]        bp_en,
    input  logic [NUM_BP*PC_W-1:0]   bp_addr,
    input  logic [CNT_W-1:0]         timeout_lim,
    input  logic [PC_W-1:0]          pc,
    output logic                     cpu_run,
    output logic [SEL_W-1:0]         reg_sel,
    input  logic [DATA_W-1:0]        reg_data,
    output logic                     dump_valid,
    input  logic                     dump_ready,
    output logic [DATA_W-1:0]        dump_data,
    output logic                     dump_last,
    output logic [1:0]               stop_cause,
    output logic [BP_IDX_W-1:0]      bp_hit_idx,
    output logic [CNT_W-1:0]         cycle_count,
    output logic                     busy,
    output logic                     done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DUMP = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int WORD_W = $clog2(NREG + 1);

    logic [1:0]          state;
    logic [WORD_W-1:0]   word_idx;
    logic [NUM_BP-1:0]   bp_hits;
    logic [BP_IDX_W-1:0] bp_first;
    logic                bp_match;
    logic                wd_hit;
    logic                stop;
    logic                accept;

    // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
    always_comb begin
        bp_hits  = '0;
        bp_first = '0;
        for (int i = 0; i < NUM_BP; i++) begin
            bp_hits[i] = bp_en[i] && (pc == bp_addr[i*PC_W +: PC_W]);
        end
        // Walk downward so the lowest matching index wins.
        for (int i = NUM_BP - 1; i >= 0; i--) begin
            if (bp_hits[i]) bp_first = BP_IDX_W'(i);
        end
    end

    assign bp_match = |bp_hits;
    assign wd_hit   = (timeout_lim != '0) && (cycle_count == timeout_lim);
    assign stop     = bp_match || wd_hit || halt_req;

    // Combinational so the CPU never executes the instruction that triggered the stop.
    assign cpu_run = (state == S_RUN) && !stop;
    assign busy    = (state == S_RUN) || (state == S_DUMP);
    assign done    = (state == S_DONE);
    assign accept  = dump_valid && dump_ready;

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            reg_sel     <= '0;
            dump_valid  <= 1'b0;
            dump_data   <= '0;
            dump_last   <= 1'b0;
            stop_cause  <= 2'd0;
            bp_hit_idx  <= '0;
            cycle_count <= '0;
            word_idx    <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (arm) begin
                        state       <= S_RUN;
                        cycle_count <= '0;
                        stop_cause  <= 2'd0;
                        reg_sel     <= '0;
                    end
                end

                S_RUN: begin
                    if (stop) begin
                        state      <= S_DUMP;
                        dump_valid <= 1'b1;
                        dump_data  <= DATA_W'(pc);
                        dump_last  <= 1'b0;
                        reg_sel    <= '0;
                        word_idx   <= '0;
                        bp_hit_idx <= bp_first;
                        stop_cause <= bp_match ? 2'd1 : (wd_hit ? 2'd2 : 2'd3);
                    end else if (cycle_count != '1) begin
                        cycle_count <= cycle_count + 1'b1;
                    end
                end

                S_DUMP: begin
                    if (accept) begin
                        if (dump_last) begin
                            state      <= S_DONE;
                            dump_valid <= 1'b0;
                            dump_last  <= 1'b0;
                        end else begin
                            // reg_sel already points at the register for the next word.
                            dump_data <= (reg_sel == '0) ? '0 : reg_data;
                            dump_last <= (word_idx == WORD_W'(NREG - 1));
                            reg_sel   <= reg_sel + 1'b1;
                            word_idx  <= word_idx + 1'b1;
                        end
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_run_ctrl_dump.sv
// Scoreboard bench for run_ctrl_dump: a stepping CPU/pc model, a fixed register-file model
// and a dump consumer that pops expected words as the DUT transfers them.
module tb_run_ctrl_dump;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } word_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        arm;
    logic        halt_req;
    logic [1:0]  bp_en;
    logic [63:0] bp_addr;
    logic [15:0] timeout_lim;
    logic [31:0] pc;
    logic        cpu_run;
    logic [4:0]  reg_sel;
    logic [31:0] reg_data;
    logic        dump_valid;
    logic        dump_ready;
    logic [31:0] dump_data;
    logic        dump_last;
    logic [1:0]  stop_cause;
    logic [0:0]  bp_hit_idx;
    logic [15:0] cycle_count;
    logic        busy;
    logic        done;

    int    n_pass  = 0;
    int    n_total = 0;
    word_t sb[$];

    always #5 clk = ~clk;

    // Register file: rf[i] = 0xA000_0000 + i, read combinationally.
    assign reg_data = 32'hA000_0000 + {27'd0, reg_sel};

    run_ctrl_dump dut (
        .clk(clk), .rst(rst), .arm(arm), .halt_req(halt_req), .bp_en(bp_en),
        .bp_addr(bp_addr), .timeout_lim(timeout_lim), .pc(pc), .cpu_run(cpu_run),
        .reg_sel(reg_sel), .reg_data(reg_data), .dump_valid(dump_valid),
        .dump_ready(dump_ready), .dump_data(dump_data), .dump_last(dump_last),
        .stop_cause(stop_cause), .bp_hit_idx(bp_hit_idx), .cycle_count(cycle_count),
        .busy(busy), .done(done)
    );

    task automatic push_words(input logic [31:0] halted_pc);
        word_t w;
        w.data = halted_pc;
        w.last = 1'b0;
        sb.push_back(w);
        for (int i = 0; i < 32; i++) begin
            w.data = (i == 0) ? 32'd0 : 32'hA000_0000 + 32'(i);
            w.last = (i == 31);
            sb.push_back(w);
        end
    endtask

    task automatic arm_pulse();
        @(posedge clk); #1 arm = 1'b1;
        @(posedge clk); #1 arm = 1'b0;
    endtask

    // CPU model: pc advances by 4 on every edge where cpu_run was high.
    task automatic run_cpu(input int budget, output int cycles);
        cycles = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!cpu_run) break;
            @(posedge clk); #1 pc = pc + 32'd4;
            cycles++;
        end
    endtask

    task automatic drain(input int max_words, input bit b2b, output int cycles);
        logic        stalled;
        logic [31:0] held_data;
        logic        held_last;
        int          words;
        word_t       w;
        stalled = 1'b0; held_data = '0; held_last = 1'b0; words = 0; cycles = 0;
        while (words < max_words && cycles < 400) begin
            @(posedge clk); #1 dump_ready = b2b ? 1'b1 : (cycles % 3 == 0);
            @(negedge clk);
            if (cycles == 0) begin
                n_total++;
                if (dump_valid !== 1'b1) $display("FAIL first_valid: got %b want 1", dump_valid);
                else n_pass++;
            end
            if (stalled) begin
                n_total++;
                if (dump_valid !== 1'b1 || dump_data !== held_data || dump_last !== held_last)
                    $display("FAIL stall_hold: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                             dump_valid, dump_data, dump_last, held_data, held_last);
                else n_pass++;
            end
            if (dump_valid && dump_ready) begin
                n_total++;
                if (sb.size() == 0) begin
                    $display("FAIL sb_empty: got word %h with no expected word", dump_data);
                end else begin
                    w = sb.pop_front();
                    if (dump_data !== w.data || dump_last !== w.last)
                        $display("FAIL dump_word%0d: got %h last=%b want %h last=%b",
                                 words, dump_data, dump_last, w.data, w.last);
                    else n_pass++;
                end
                words++;
                stalled = 1'b0;
            end else begin
                stalled   = dump_valid;
                held_data = dump_data;
                held_last = dump_last;
            end
            cycles++;
        end
        if (words < max_words) begin
            n_total++;
            $display("FAIL drain_timeout: got %0d words want %0d", words, max_words);
        end
    endtask

    task automatic finish_dump(input logic [1:0] cause, input logic idx, input logic [15:0] cnt);
        @(posedge clk); #1 dump_ready = 1'b0;
        @(negedge clk);
        n_total++;
        if ({dump_valid, done, busy, cpu_run} !== 4'b0100)
            $display("FAIL done_state: got v/done/busy/run=%b want 0100",
                     {dump_valid, done, busy, cpu_run});
        else n_pass++;
        n_total++;
        if (stop_cause !== cause || bp_hit_idx !== idx || cycle_count !== cnt)
            $display("FAIL stop_info: got cause=%0d idx=%0d cnt=%0d want cause=%0d idx=%0d cnt=%0d",
                     stop_cause, bp_hit_idx, cycle_count, cause, idx, cnt);
        else n_pass++;
        n_total++;
        if (sb.size() != 0) $display("FAIL sb_leftover: got %0d words want 0", sb.size());
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1; arm = 1'b0; halt_req = 1'b0; bp_en = 2'b00; bp_addr = '0;
        timeout_lim = '0; pc = '0; dump_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_total++;
        if ({cpu_run, reg_sel, dump_valid, dump_data, dump_last, stop_cause, bp_hit_idx,
             cycle_count, busy, done} !== '0)
            $display("FAIL reset_outputs: got run=%b sel=%0d v=%b d=%h l=%b c=%0d i=%0d n=%0d b=%b dn=%b want all 0",
                     cpu_run, reg_sel, dump_valid, dump_data, dump_last, stop_cause,
                     bp_hit_idx, cycle_count, busy, done);
        else n_pass++;
        #1 rst = 1'b0;
    endtask

    task automatic test_breakpoint();
        int cyc;
        bp_en = 2'b01;
        bp_addr[31:0] = 32'h48;
        arm_pulse();
        run_cpu(100, cyc);
        n_total++;
        if (cyc !== 18 || pc !== 32'h48)
            $display("FAIL bp_stop_point: got cycles=%0d pc=%h want 18 / 00000048", cyc, pc);
        else n_pass++;
        n_total++;
        if (cpu_run !== 1'b0 || busy !== 1'b1)
            $display("FAIL bp_cpu_run: got run=%b busy=%b want 0 1", cpu_run, busy);
        else n_pass++;
        push_words(32'h48);
        drain(33, 1'b0, cyc);
        finish_dump(2'd1, 1'b0, 16'd18);
    endtask

    task automatic test_rearm_watchdog();
        int cyc;
        bp_en = 2'b00;
        timeout_lim = 16'd10;
        arm_pulse();
        @(negedge clk);
        n_total++;
        if ({cpu_run, busy, done} !== 3'b110 || cycle_count !== 16'd0)
            $display("FAIL rearm: got run/busy/done=%b cnt=%0d want 110 cnt=0",
                     {cpu_run, busy, done}, cycle_count);
        else n_pass++;
        @(posedge clk); #1 pc = pc + 32'd4;
        run_cpu(50, cyc);
        n_total++;
        if (cyc + 1 !== 10) $display("FAIL wd_cycles: got %0d want 10", cyc + 1);
        else n_pass++;
        push_words(32'h70);
        drain(33, 1'b1, cyc);
        n_total++;
        if (cyc !== 33) $display("FAIL back_to_back: got %0d cycles want 33", cyc);
        else n_pass++;
        finish_dump(2'd2, 1'b0, 16'd10);
    endtask

    task automatic test_wd_disabled_halt();
        int cyc;
        timeout_lim = 16'd0;
        arm_pulse();
        run_cpu(1000, cyc);
        n_total++;
        if (cyc !== 1000 || cycle_count !== 16'd1000 || busy !== 1'b1)
            $display("FAIL wd_disabled: got cycles=%0d cnt=%0d busy=%b want 1000 1000 1",
                     cyc, cycle_count, busy);
        else n_pass++;
        halt_req = 1'b1;
        run_cpu(5, cyc);
        n_total++;
        if (cyc !== 0) $display("FAIL halt_stop: got %0d cycles want 0", cyc);
        else n_pass++;
        push_words(pc);
        drain(33, 1'b1, cyc);
        halt_req = 1'b0;
        finish_dump(2'd3, 1'b0, 16'd1000);
    endtask

    task automatic test_priority();
        int cyc;
        // Breakpoint, watchdog and halt all coincide at the third step.
        timeout_lim = 16'd3;
        bp_en = 2'b01;
        bp_addr[31:0] = pc + 32'd12;
        arm_pulse();
        run_cpu(3, cyc);
        halt_req = 1'b1;
        run_cpu(5, cyc);
        n_total++;
        if (cyc !== 0) $display("FAIL prio_all_stop: got %0d cycles want 0", cyc);
        else n_pass++;
        push_words(pc);
        drain(33, 1'b1, cyc);
        halt_req = 1'b0;
        finish_dump(2'd1, 1'b0, 16'd3);

        // Watchdog and halt coincide.
        bp_en = 2'b00;
        timeout_lim = 16'd2;
        arm_pulse();
        run_cpu(2, cyc);
        halt_req = 1'b1;
        run_cpu(5, cyc);
        push_words(pc);
        drain(33, 1'b1, cyc);
        halt_req = 1'b0;
        finish_dump(2'd2, 1'b0, 16'd2);

        // Both breakpoints on the halted pc: immediate stop, lowest index reported.
        timeout_lim = 16'd0;
        bp_addr = {pc, pc};
        bp_en = 2'b11;
        arm_pulse();
        run_cpu(5, cyc);
        n_total++;
        if (cyc !== 0) $display("FAIL bp_immediate: got %0d cycles want 0", cyc);
        else n_pass++;
        push_words(pc);
        drain(33, 1'b1, cyc);
        finish_dump(2'd1, 1'b0, 16'd0);
    endtask

    task automatic test_reset_mid_dump();
        int cyc;
        arm_pulse();
        run_cpu(5, cyc);
        push_words(pc);
        drain(6, 1'b1, cyc);
        @(posedge clk); #1 begin rst = 1'b1; dump_ready = 1'b0; end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        n_total++;
        if ({cpu_run, reg_sel, dump_valid, dump_data, dump_last, stop_cause, bp_hit_idx,
             cycle_count, busy, done} !== '0)
            $display("FAIL reset_mid_dump: got run=%b sel=%0d v=%b d=%h l=%b c=%0d i=%0d n=%0d b=%b dn=%b want all 0",
                     cpu_run, reg_sel, dump_valid, dump_data, dump_last, stop_cause,
                     bp_hit_idx, cycle_count, busy, done);
        else n_pass++;
        sb.delete();

        bp_en = 2'b01;
        bp_addr[31:0] = pc + 32'd8;
        arm_pulse();
        run_cpu(10, cyc);
        n_total++;
        if (cyc !== 2) $display("FAIL restart_stop: got %0d cycles want 2", cyc);
        else n_pass++;
        push_words(pc);
        drain(33, 1'b0, cyc);
        finish_dump(2'd1, 1'b0, 16'd2);
    endtask

    initial begin
        test_reset();
        test_breakpoint();
        test_rearm_watchdog();
        test_wd_disabled_halt();
        test_priority();
        test_reset_mid_dump();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no completion want completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
